// File: rtl/irq_pending_latch.sv
// Interrupt source latch: turns peripheral event pulses into level-held interrupt
// lines that stay high until acknowledged, with overflow, bad-ack and timeout flags.
module irq_pending_latch #(
    parameter logic [31:0] VALID_MASK = 32'hFFFF_0888,
    parameter int          TIMEOUT    = 1024,
    parameter int          TO_W       = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_evt_i,
    input  logic [31:0] irq_clr_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    output logic [31:0] irq_o,
    output logic [31:0] overflow_o,
    output logic        ack_err_o,
    output logic        timeout_o
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    logic [31:0]     irq_q;
    logic [31:0]     ovf_q;
    logic            ack_err_q;
    logic            timeout_q;
    logic [TO_W-1:0] cnt_q;

    logic [31:0]     evt_v;
    logic            ack_hit;
    logic [31:0]     ack_vec;
    logic            cnt_clr;
    logic [31:0]     irq_next;
    logic [31:0]     ovf_next;
    logic [TO_W-1:0] cnt_next;
    logic            timeout_next;

    // A new event always wins over an ack or clear landing in the same cycle;
    // overflow only counts a repeat event that is not being retired this cycle.
    always_comb begin
        evt_v    = irq_evt_i & VALID_MASK;
        ack_hit  = irq_ack_i && VALID_MASK[irq_id_i] && irq_q[irq_id_i];
        ack_vec  = ack_hit ? (32'd1 << irq_id_i) : 32'd0;
        irq_next = ((irq_q & ~ack_vec & ~irq_clr_i) | evt_v) & VALID_MASK;
        ovf_next = (ovf_q | (evt_v & irq_q & ~ack_vec & ~irq_clr_i)) & ~irq_clr_i & VALID_MASK;

        cnt_clr  = ack_hit || (irq_q == 32'd0);
        cnt_next = cnt_q;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (cnt_q != TO_LIMIT) begin
            cnt_next = cnt_q + TO_W'(1);
        end

        // Drop the flag in the same edge that retires the wait, not one later.
        timeout_next = (cnt_q == TO_LIMIT) && !cnt_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            ovf_q     <= '0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            irq_q     <= irq_next;
            ovf_q     <= ovf_next;
            ack_err_q <= irq_ack_i && !ack_hit;
            timeout_q <= timeout_next;
            cnt_q     <= cnt_next;
        end
    end

    assign irq_o      = irq_q;
    assign overflow_o = ovf_q;
    assign ack_err_o  = ack_err_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: table-driven single-cycle vectors plus
// hand-written timeout and reset sequences, compared through an expectation queue.
module tb_irq_pending_latch;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_evt_i;
    logic [31:0] irq_clr_i;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic [31:0] irq_o;
    logic [31:0] overflow_o;
    logic        ack_err_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] evt;
        logic [31:0] clr;
        logic        ack;
        logic [4:0]  id;
        logic [31:0] exp_irq;
        logic [31:0] exp_ovf;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] irq;
        logic [31:0] ovf;
        logic        err;
        logic        to;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[20];

    irq_pending_latch #(
        .VALID_MASK(32'hFFFF_0888),
        .TIMEOUT   (8),
        .TO_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_evt_i (irq_evt_i),
        .irq_clr_i (irq_clr_i),
        .irq_ack_i (irq_ack_i),
        .irq_id_i  (irq_id_i),
        .irq_o     (irq_o),
        .overflow_o(overflow_o),
        .ack_err_o (ack_err_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] evt, input logic [31:0] clr,
                                  input logic ack, input logic [4:0] id,
                                  input logic [31:0] e_irq, input logic [31:0] e_ovf,
                                  input logic e_err, input logic e_to, input string name);
        exp_t e;
        @(negedge clk);
        irq_evt_i = evt;
        irq_clr_i = clr;
        irq_ack_i = ack;
        irq_id_i  = id;
        e.irq = e_irq; e.ovf = e_ovf; e.err = e_err; e.to = e_to; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        irq_evt_i = '0;
        irq_clr_i = '0;
        irq_ack_i = 1'b0;
        irq_id_i  = '0;
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = exp_q.pop_front();
            compare({e.name, ".irq"}, irq_o, e.irq);
            compare({e.name, ".ovf"}, overflow_o, e.ovf);
            compare({e.name, ".err"}, {31'd0, ack_err_o}, {31'd0, e.err});
            compare({e.name, ".to"}, {31'd0, timeout_o}, {31'd0, e.to});
        end
    endtask

    task automatic step(input logic [31:0] evt, input logic [31:0] clr,
                        input logic ack, input logic [4:0] id,
                        input logic [31:0] e_irq, input logic [31:0] e_ovf,
                        input logic e_err, input logic e_to, input string name);
        apply_stimulus(evt, clr, ack, id, e_irq, e_ovf, e_err, e_to, name);
        check_output();
    endtask

    initial begin
        //          evt            clr            ack   id     irq            ovf          err   to
        vecs[0]  = '{32'h0000_0080, 32'h0,        1'b0, 5'd0,  32'h0000_0080, 32'h0,       1'b0, 1'b0};
        vecs[1]  = '{32'h0,         32'h0,        1'b0, 5'd0,  32'h0000_0080, 32'h0,       1'b0, 1'b0};
        vecs[2]  = '{32'h0,         32'h0,        1'b1, 5'd7,  32'h0,         32'h0,       1'b0, 1'b0};
        vecs[3]  = '{32'h0000_1021, 32'h0,        1'b0, 5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0008, 32'h0,        1'b0, 5'd0,  32'h0000_0008, 32'h0,       1'b0, 1'b0};
        vecs[5]  = '{32'h0,         32'h0,        1'b0, 5'd0,  32'h0000_0008, 32'h0,       1'b0, 1'b0};
        vecs[6]  = '{32'h0000_0008, 32'h0,        1'b0, 5'd0,  32'h0000_0008, 32'h8,       1'b0, 1'b0};
        vecs[7]  = '{32'h0,         32'h0000_0008,1'b0, 5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0800, 32'h0,        1'b0, 5'd0,  32'h0000_0800, 32'h0,       1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0800, 32'h0,        1'b1, 5'd11, 32'h0000_0800, 32'h0,       1'b0, 1'b0};
        vecs[10] = '{32'h0,         32'h0,        1'b1, 5'd16, 32'h0000_0800, 32'h0,       1'b1, 1'b0};
        vecs[11] = '{32'h0,         32'h0,        1'b1, 5'd11, 32'h0,         32'h0,       1'b0, 1'b0};
        vecs[12] = '{32'h0000_0080, 32'h0,        1'b0, 5'd0,  32'h0000_0080, 32'h0,       1'b0, 1'b0};
        vecs[13] = '{32'h0,         32'h0,        1'b1, 5'd7,  32'h0,         32'h0,       1'b0, 1'b0};
        vecs[14] = '{32'h0,         32'h0,        1'b1, 5'd7,  32'h0,         32'h0,       1'b1, 1'b0};
        vecs[15] = '{32'h0,         32'h0,        1'b0, 5'd0,  32'h0,         32'h0,       1'b0, 1'b0};
        vecs[16] = '{32'h0,         32'h0,        1'b1, 5'd5,  32'h0,         32'h0,       1'b1, 1'b0};
        vecs[17] = '{32'hFFFF_FFFF, 32'h0,        1'b0, 5'd0,  32'hFFFF_0888, 32'h0,       1'b0, 1'b0};
        vecs[18] = '{32'h8000_0000, 32'hFFFF_FFFF,1'b0, 5'd0,  32'h8000_0000, 32'h0,       1'b0, 1'b0};
        vecs[19] = '{32'h0,         32'hFFFF_FFFF,1'b0, 5'd0,  32'h0,         32'h0,       1'b0, 1'b0};

        rst_n     = 1'b0;
        irq_evt_i = '0;
        irq_clr_i = '0;
        irq_ack_i = 1'b0;
        irq_id_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        compare("reset.irq", irq_o, 32'h0);
        compare("reset.ovf", overflow_o, 32'h0);
        compare("reset.err", {31'd0, ack_err_o}, 32'd0);
        compare("reset.to", {31'd0, timeout_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].evt, vecs[i].clr, vecs[i].ack, vecs[i].id,
                 vecs[i].exp_irq, vecs[i].exp_ovf, vecs[i].exp_err, vecs[i].exp_to,
                 $sformatf("vec%0d", i));
        end

        // Bit 20 raised and left unacknowledged: timeout on the ninth cycle after it rises.
        step(32'h0010_0000, 32'h0, 1'b0, 5'd0, 32'h0010_0000, 32'h0, 1'b0, 1'b0, "to_raise");
        for (int k = 1; k <= 9; k++) begin
            step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0010_0000, 32'h0, 1'b0, (k == 9),
                 $sformatf("to_wait%0d", k));
        end
        step(32'h0, 32'h0, 1'b1, 5'd20, 32'h0, 32'h0, 1'b0, 1'b0, "to_ack");

        // Build up state, then pull reset between edges and expect an immediate clear.
        step(32'h0000_0008, 32'h0, 1'b0, 5'd0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, "rst_pre1");
        step(32'h0000_0008, 32'h0, 1'b1, 5'd16, 32'h0000_0008, 32'h8, 1'b1, 1'b0, "rst_pre2");
        @(negedge clk);
        irq_evt_i = 32'h0000_0080;
        #2;
        rst_n = 1'b0;
        #1;
        compare("rst_async.irq", irq_o, 32'h0);
        compare("rst_async.ovf", overflow_o, 32'h0);
        compare("rst_async.err", {31'd0, ack_err_o}, 32'd0);
        @(posedge clk);
        #1;
        compare("rst_hold.irq", irq_o, 32'h0);
        irq_evt_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_0080, 32'h0, 1'b0, 5'd0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, "post_rst_evt");

        compare("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Interrupt source latch sitting directly upstream of the core's interrupt interface. It converts single-cycle peripheral event pulses into level-held `irq_i` lines, holds each line until the core acknowledges that ID via `irq_ack_o`/`irq_id_o`, and flags overflow, bad acknowledges and acknowledge timeouts. Its outputs are the stimulus side of the interrupt checkers: only legal IDs are raised, and every raised line is held until acknowledged.

## Interface
- `VALID_MASK`, 32'hFFFF_0888: legal interrupt IDs (3, 7, 11, 16-31); all other bits are forced to 0.
- `TIMEOUT`, 1024: cycles a pending interrupt may wait for an acknowledge before `timeout_o` asserts (must be ≥1).
- `TO_W`, 11: timeout counter width; must satisfy 2^TO_W > TIMEOUT.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_evt_i`  in  32  per-source event pulses; a 1 in any cycle is one event.
- `irq_clr_i`  in  32  software clear of pending and overflow, per bit.
- `irq_ack_i`  in  1  core interrupt acknowledge (the core's `irq_ack_o`).
- `irq_id_i`  in  5  acknowledged ID (the core's `irq_id_o`), valid when `irq_ack_i`=1.
- `irq_o`  out  32  level interrupt lines to the core's `irq_i`.
- `overflow_o`  out  32  sticky per-source flag: an event arrived while the source was already pending.
- `ack_err_o`  out  1  one-cycle pulse: an acknowledge named an illegal or non-pending ID.
- `timeout_o`  out  1  pending interrupts unacknowledged for `TIMEOUT` cycles.

## Operation
- Reset values: `irq_o`, `overflow_o`, `ack_err_o`, `timeout_o` and the timeout counter are all 0.
- `evt_v = irq_evt_i & VALID_MASK`; events on illegal bits are ignored entirely.
- `ack_hit = irq_ack_i && VALID_MASK[irq_id_i] && irq_o[irq_id_i]`; `ack_vec = ack_hit ? (1<<irq_id_i) : 0`.
- Pending update: `irq_o_next = ((irq_o & ~ack_vec & ~irq_clr_i) | evt_v) & VALID_MASK`. A new event always wins over an ack or clear in the same cycle.
- Overflow set: for bit i, set when `evt_v[i] && irq_o[i]` and bit i is not acknowledged and not cleared in that cycle.
- Overflow clear: by `irq_clr_i[i]`. If clear and set occur together, clear wins. An ack never clears overflow.
- `ack_err_o_next = irq_ack_i && !ack_hit`. This includes an ack held high for a second cycle, because the ID is no longer pending.
- Timeout counter:
  - Clears to 0 when `ack_hit` is 1, or when `irq_o == 0`.
  - Otherwise increments, saturating at `TIMEOUT`.
  - `timeout_o` is registered and equals `(cnt == TIMEOUT)`.
- No state machine beyond the pending, overflow and counter registers. All outputs are registered, with no combinational input-to-output path.

## Timing
- Event in cycle N → `irq_o` bit high at N+1. It stays high until an ack or clear is sampled, then drops one cycle later.
- Ack sampled in cycle N → bit low at N+1. `ack_err_o` is high only during N+1 when the ack is bad.
- The timeout counter starts counting the first cycle `irq_o != 0`. `timeout_o` rises `TIMEOUT`+1 cycles after `irq_o` first goes nonzero with no ack.
- `timeout_o` falls the cycle after an ack hit, or the cycle after `irq_o` becomes 0.
- Reset asserted mid-operation: every register clears immediately (asynchronously). Events in flight are lost. The first events are accepted at the first rising edge after `rst_n` deasserts.
- Multiple simultaneous events are all latched in the same cycle. Prioritisation is the core's job.

## Test plan
- Event pulse on bit 7 at cycle 5, ack ID 7 at cycle 12 → `irq_o[7]` is 1 from cycle 6 to cycle 12 and 0 at cycle 13; `ack_err_o` stays 0.
- Events on bits 0, 5 and 12 → `irq_o` remains 0 and `overflow_o` remains 0.
- Two events on bit 3, four cycles apart, with no ack → `overflow_o[3]`=1 one cycle after the second event; `irq_clr_i[3]` → both `irq_o[3]` and `overflow_o[3]` are 0 on the next cycle.
- Event and ack for bit 11 in the same cycle while bit 11 is pending → `irq_o[11]` stays 1 and `overflow_o[11]` stays 0.
- Ack ID 16 while bit 16 is not pending, then ack ID 7 held for 2 cycles after a bit-7 event → `ack_err_o` pulses once for the first case and once for the second cycle of the held ack.
- With `TIMEOUT`=8, raise bit 20 and never ack → `timeout_o`=1 at cycle 9 after `irq_o[20]` rises; ack ID 20 → `timeout_o`=0 on the next cycle. Assert `rst_n`=0 mid-test → all outputs 0 immediately.
